// File: rtl/standard_decimator_pkg.sv
// Shared sizing helpers and constants for the standard decimator slice.
package standard_decimator_pkg;

    // Width of the stream dest field; channels beyond MAX_CHANNELS are still addressable so they can be discarded.
    localparam int DEST_WIDTH = 4;

    // Accumulator must hold the sum of a full group of max-ratio samples without wrapping.
    function automatic int acc_width(input int data_width, input int max_ratio);
        return data_width + $clog2(max_ratio);
    endfunction

    // Counter and ratio width: must be able to represent max_ratio itself.
    function automatic int cnt_width(input int max_ratio);
        return $clog2(max_ratio) + 1;
    endfunction

endpackage

// File: rtl/standard_decimator_if.sv
// Minimal AXI-stream style link (valid/ready/data/dest) used for both decimator ports.
interface standard_decimator_if
    import standard_decimator_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) ();

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;

    modport master (output valid, output data, output dest, input ready);
    modport slave  (input valid, input data, input dest, output ready);

endinterface

// File: rtl/standard_decimator_channel.sv
// One decimation channel: sample counter, signed accumulator and group-completion detect.
module decimator_channel
    import standard_decimator_pkg::*;
#(
    parameter  int DATA_WIDTH           = 16,
    parameter  int MAX_DECIMATION_RATIO = 16,
    localparam int ACC_W                = acc_width(DATA_WIDTH, MAX_DECIMATION_RATIO),
    localparam int CNT_W                = cnt_width(MAX_DECIMATION_RATIO)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    hit,
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic        [CNT_W-1:0] ratio,
    output logic                    done,
    output logic signed [ACC_W-1:0] total
);

    logic        [CNT_W-1:0] count;
    logic        [CNT_W-1:0] count_next;
    logic signed [ACC_W-1:0] acc;

    // Running total including the sample on the input; completion uses >= so a ratio lowered mid-group ends it on the next sample.
    always_comb begin
        count_next = count + CNT_W'(1);
        total      = acc + ACC_W'(sample);
        done       = hit && (count_next >= ratio);
    end

    // Accumulate each accepted sample, restarting from zero when the group completes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            acc   <= '0;
        end else if (hit) begin
            if (done) begin
                count <= '0;
                acc   <= '0;
            end else begin
                count <= count_next;
                acc   <= total;
            end
        end
    end

endmodule

// File: rtl/standard_decimator.sv
// Multi-channel decimator: routes samples by dest to per-channel accumulators and emits one output per completed group.
module standard_decimator
    import standard_decimator_pkg::*;
#(
    parameter  int MAX_DECIMATION_RATIO = 16,
    parameter  int MAX_CHANNELS         = 6,
    parameter  int DATA_WIDTH           = 16,
    parameter  int AVERAGING            = 1,
    localparam int CNT_W                = cnt_width(MAX_DECIMATION_RATIO)
) (
    input  logic                 clock,
    input  logic                 reset,
    standard_decimator_if.slave  data_in,
    standard_decimator_if.master data_out,
    input  logic [CNT_W-1:0]     decimation_ratio
);

    localparam int ACC_W = acc_width(DATA_WIDTH, MAX_DECIMATION_RATIO);

    logic        [CNT_W-1:0]      ratio_eff;
    logic        [CNT_W-1:0]      shift_amt;
    logic signed [DATA_WIDTH-1:0] sample;
    logic        [MAX_CHANNELS-1:0] hit;
    logic        [MAX_CHANNELS-1:0] done;
    logic signed [ACC_W-1:0]      totals [MAX_CHANNELS];
    logic signed [ACC_W-1:0]      group_total;
    logic                         group_done;
    logic        [DATA_WIDTH-1:0] out_next;
    logic                         out_valid;
    logic        [DATA_WIDTH-1:0] out_data;
    logic        [DEST_WIDTH-1:0] out_dest;
    logic                         unused_ready;

    // The block never stalls, so it is ready whenever it is out of reset; downstream ready is not consulted.
    assign data_in.ready  = reset;
    assign unused_ready   = data_out.ready;
    assign sample         = data_in.data;

    // Clamp the requested ratio into 1..MAX and derive floor(log2(N)) for the averaging shift.
    always_comb begin
        if (decimation_ratio == '0) begin
            ratio_eff = CNT_W'(1);
        end else if (decimation_ratio > CNT_W'(MAX_DECIMATION_RATIO)) begin
            ratio_eff = CNT_W'(MAX_DECIMATION_RATIO);
        end else begin
            ratio_eff = decimation_ratio;
        end
        shift_amt = '0;
        for (int b = 0; b < CNT_W; b++) begin
            if (ratio_eff[b]) begin
                shift_amt = CNT_W'(b);
            end
        end
    end

    for (genvar i = 0; i < MAX_CHANNELS; i++) begin : g_channel
        assign hit[i] = data_in.valid && data_in.ready && (data_in.dest == DEST_WIDTH'(i));

        decimator_channel #(
            .DATA_WIDTH           (DATA_WIDTH),
            .MAX_DECIMATION_RATIO (MAX_DECIMATION_RATIO)
        ) u_channel (
            .clock  (clock),
            .reset  (reset),
            .hit    (hit[i]),
            .sample (sample),
            .ratio  (ratio_eff),
            .done   (done[i]),
            .total  (totals[i])
        );
    end

    // Select the addressed channel's result and form either the group mean or the last sample.
    always_comb begin
        group_done  = 1'b0;
        group_total = '0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            group_done = group_done | done[i];
            if (hit[i]) begin
                group_total = totals[i];
            end
        end
        if (AVERAGING != 0) begin
            out_next = DATA_WIDTH'(group_total >>> shift_amt);
        end else begin
            out_next = data_in.data;
        end
    end

    // Output register: single-cycle valid pulse per completed group, data/dest held until the next one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dest  <= '0;
        end else begin
            out_valid <= group_done;
            if (group_done) begin
                out_data <= out_next;
                out_dest <= data_in.dest;
            end
        end
    end

    assign data_out.valid = out_valid;
    assign data_out.data  = out_data;
    assign data_out.dest  = out_dest;

endmodule

// File: tb/tb_standard_decimator.sv
// Directed self-checking bench: one averaging and one last-sample decimator driven with identical stimulus.
module tb_standard_decimator;
    import standard_decimator_pkg::*;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_dest;
    logic [15:0] in_data;
    logic [4:0]  ratio;
    int          vectors;
    int          miscompares;
    int          avg_pulses;
    int          base;

    standard_decimator_if #(.DATA_WIDTH(16)) avg_in  ();
    standard_decimator_if #(.DATA_WIDTH(16)) avg_out ();
    standard_decimator_if #(.DATA_WIDTH(16)) last_in ();
    standard_decimator_if #(.DATA_WIDTH(16)) last_out ();

    assign avg_in.valid   = in_valid;
    assign avg_in.dest    = in_dest;
    assign avg_in.data    = in_data;
    assign avg_out.ready  = 1'b1;
    assign last_in.valid  = in_valid;
    assign last_in.dest   = in_dest;
    assign last_in.data   = in_data;
    assign last_out.ready = 1'b1;

    standard_decimator #(.MAX_DECIMATION_RATIO(16), .MAX_CHANNELS(6), .DATA_WIDTH(16), .AVERAGING(1)) dut_avg (
        .clock            (clock),
        .reset            (reset),
        .data_in          (avg_in),
        .data_out         (avg_out),
        .decimation_ratio (ratio)
    );

    standard_decimator #(.MAX_DECIMATION_RATIO(16), .MAX_CHANNELS(6), .DATA_WIDTH(16), .AVERAGING(0)) dut_last (
        .clock            (clock),
        .reset            (reset),
        .data_in          (last_in),
        .data_out         (last_out),
        .decimation_ratio (ratio)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (avg_out.valid) avg_pulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present one sample for one clock; returns 1 time unit after the edge so outputs can be sampled.
    task automatic applyStimulus(input logic [3:0] d, input logic [15:0] x);
        in_valid = 1'b1;
        in_dest  = d;
        in_data  = x;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        avg_pulses  = 0;
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_dest     = '0;
        in_data     = '0;
        ratio       = 5'd4;

        idleCycles(2);
        checkOutput("reset_valid", 32'(avg_out.valid), 32'd0);
        checkOutput("reset_data",  32'(avg_out.data),  32'd0);
        checkOutput("reset_dest",  32'(avg_out.dest),  32'd0);
        checkOutput("reset_ready", 32'(avg_in.ready),  32'd0);
        reset = 1'b1;
        #1;
        checkOutput("ready_after_reset", 32'(avg_in.ready), 32'd1);

        // N=4 mean of -10,-7,-3,4 on dest 3 = -16/4 = -4
        base = avg_pulses;
        applyStimulus(4'd3, 16'hFFF6);
        applyStimulus(4'd3, 16'hFFF9);
        applyStimulus(4'd3, 16'hFFFD);
        checkOutput("mean_no_early_pulse", 32'(avg_out.valid), 32'd0);
        applyStimulus(4'd3, 16'h0004);
        checkOutput("mean_valid", 32'(avg_out.valid), 32'd1);
        checkOutput("mean_data",  32'(avg_out.data),  32'h0000FFFC);
        checkOutput("mean_dest",  32'(avg_out.dest),  32'd3);
        checkOutput("last_of_mean_group", 32'(last_out.data), 32'h4);
        idleCycles(1);
        checkOutput("pulse_one_cycle", 32'(avg_out.valid), 32'd0);
        checkOutput("data_held",       32'(avg_out.data),  32'h0000FFFC);
        checkOutput("mean_pulse_count", 32'(avg_pulses - base), 32'd1);

        // Full-scale positive and negative groups must not wrap
        repeat (4) applyStimulus(4'd0, 16'h7FFF);
        checkOutput("max_pos_data", 32'(avg_out.data), 32'h7FFF);
        repeat (4) applyStimulus(4'd0, 16'h8000);
        checkOutput("max_neg_data", 32'(avg_out.data), 32'h8000);

        // Interleaved channels, N=2; then out-of-range dests are discarded
        ratio = 5'd2;
        applyStimulus(4'd0, 16'd10);
        applyStimulus(4'd1, 16'd100);
        applyStimulus(4'd0, 16'd20);
        checkOutput("ilv_ch0_data", 32'(avg_out.data), 32'd15);
        checkOutput("ilv_ch0_dest", 32'(avg_out.dest), 32'd0);
        applyStimulus(4'd1, 16'd200);
        checkOutput("ilv_ch1_data", 32'(avg_out.data), 32'd150);
        checkOutput("ilv_ch1_dest", 32'(avg_out.dest), 32'd1);
        idleCycles(1);
        base = avg_pulses;
        applyStimulus(4'd7, 16'd1000);
        applyStimulus(4'd7, 16'd1000);
        applyStimulus(4'd6, 16'd1000);
        applyStimulus(4'd6, 16'd1000);
        applyStimulus(4'd15, 16'd1000);
        idleCycles(1);
        checkOutput("bad_dest_no_pulse", 32'(avg_pulses - base), 32'd0);
        applyStimulus(4'd0, 16'd30);
        applyStimulus(4'd0, 16'd50);
        checkOutput("ch0_after_bad_dest", 32'(avg_out.data), 32'd40);

        // Last-sample mode vs mean: 1,2,3,9 -> last 9, mean floor(15/4)=3
        ratio = 5'd4;
        applyStimulus(4'd2, 16'd1);
        applyStimulus(4'd2, 16'd2);
        applyStimulus(4'd2, 16'd3);
        applyStimulus(4'd2, 16'd9);
        checkOutput("last_mode_data",  32'(last_out.data),  32'd9);
        checkOutput("last_mode_valid", 32'(last_out.valid), 32'd1);
        checkOutput("last_mode_dest",  32'(last_out.dest),  32'd2);
        checkOutput("mean_floor",      32'(avg_out.data),   32'd3);

        // N=1 echoes each sample one cycle later
        ratio = 5'd1;
        applyStimulus(4'd4, 16'd5);
        checkOutput("n1_echo_a",      32'(last_out.data), 32'd5);
        applyStimulus(4'd4, 16'hFFFD);
        checkOutput("n1_echo_b",      32'(last_out.data), 32'hFFFD);
        checkOutput("n1_echo_b_mean", 32'(avg_out.data),  32'hFFFD);
        applyStimulus(4'd4, 16'd77);
        checkOutput("n1_echo_c",      32'(avg_out.data),  32'd77);
        checkOutput("n1_echo_c_valid", 32'(avg_out.valid), 32'd1);

        // Ratio 0 behaves as 1
        ratio = 5'd0;
        applyStimulus(4'd4, 16'd123);
        checkOutput("ratio0_valid", 32'(avg_out.valid), 32'd1);
        checkOutput("ratio0_data",  32'(avg_out.data),  32'd123);
        idleCycles(1);

        // Ratio 31 saturates to 16
        ratio = 5'd31;
        repeat (15) applyStimulus(4'd5, 16'd2);
        checkOutput("sat_no_pulse_at_15", 32'(avg_out.valid), 32'd0);
        applyStimulus(4'd5, 16'd2);
        checkOutput("sat_pulse_at_16", 32'(avg_out.valid), 32'd1);
        checkOutput("sat_data",        32'(avg_out.data),  32'd2);

        // Lowering the ratio mid-group completes on the next sample: 4 samples of 4, N=2 -> 16>>1 = 8
        ratio = 5'd8;
        applyStimulus(4'd1, 16'd4);
        applyStimulus(4'd1, 16'd4);
        applyStimulus(4'd1, 16'd4);
        checkOutput("ratio_drop_no_pulse", 32'(avg_out.valid), 32'd0);
        ratio = 5'd2;
        applyStimulus(4'd1, 16'd4);
        checkOutput("ratio_drop_valid", 32'(avg_out.valid), 32'd1);
        checkOutput("ratio_drop_data",  32'(avg_out.data),  32'd8);

        // Reset mid-group discards the partial sum
        ratio = 5'd4;
        applyStimulus(4'd0, 16'd100);
        applyStimulus(4'd0, 16'd100);
        reset = 1'b0;
        #1;
        checkOutput("async_reset_data",  32'(avg_out.data),  32'd0);
        checkOutput("async_reset_valid", 32'(avg_out.valid), 32'd0);
        checkOutput("async_reset_ready", 32'(avg_in.ready),  32'd0);
        idleCycles(2);
        checkOutput("reset_hold_data", 32'(last_out.data), 32'd0);
        reset = 1'b1;
        idleCycles(1);
        base = avg_pulses;
        applyStimulus(4'd0, 16'd8);
        applyStimulus(4'd0, 16'd8);
        applyStimulus(4'd0, 16'd8);
        checkOutput("post_reset_no_early", 32'(avg_out.valid), 32'd0);
        applyStimulus(4'd0, 16'd8);
        checkOutput("post_reset_data", 32'(avg_out.data), 32'd8);
        idleCycles(1);
        checkOutput("post_reset_pulses", 32'(avg_pulses - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/standard_decimator.md
STANDARD_DECIMATOR -- requirements
Module: standard_decimator

Interface
REQ-001 The block SHALL have parameter MAX_DECIMATION_RATIO, default 16, the largest supported decimation ratio.
REQ-002 The block SHALL have parameter MAX_CHANNELS, default 6, the number of independent channels selected by dest.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 16, the signed sample width.
REQ-004 The block SHALL have parameter AVERAGING, default 1: 1 = output the group mean, 0 = output the last sample of the group.
REQ-005 The block SHALL have port clock, input, 1 bit; one clock, all logic on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-007 The block SHALL have port data_in, axi_stream slave, DATA_WIDTH data plus dest; carries input samples.
REQ-008 The block SHALL have port data_out, axi_stream master, DATA_WIDTH data plus dest; carries decimated samples.
REQ-009 The block SHALL have port decimation_ratio, input, clog2(MAX_DECIMATION_RATIO)+1 bits; the decimation ratio N.

Function
REQ-010 data_in.ready SHALL be 1 whenever reset is high; a sample is accepted on every clock with data_in.valid=1.
REQ-011 Each dest value 0..MAX_CHANNELS-1 SHALL own an independent sample counter and a signed accumulator of DATA_WIDTH+clog2(MAX_DECIMATION_RATIO) bits.
REQ-012 A sample with dest >= MAX_CHANNELS SHALL be accepted and discarded, and no channel state SHALL change.
REQ-013 Each accepted sample SHALL be sign-extended and added to its channel accumulator, and the channel counter SHALL increment.
REQ-014 When a channel's N-th sample is accepted, the group SHALL complete: counter and accumulator clear to 0 in the same cycle, with no lost sample.
REQ-015 With AVERAGING=1, output = accumulator total arithmetically shifted right by log2(N) (floor), truncated to DATA_WIDTH, with no overflow for any input.
REQ-016 With AVERAGING=1, N SHALL be a power of two (1, 2, 4, 8, 16); for a non-power-of-two N, the shift SHALL be floor(log2(N)) (result undefined).
REQ-017 With AVERAGING=0, output SHALL be the N-th (last) sample of the group, unmodified.
REQ-018 Latency: data_out.valid SHALL be a one-cycle pulse on the clock after the N-th sample is accepted.
REQ-019 data_out.dest SHALL equal the channel's dest, and data_out.data SHALL be held until the next output.
REQ-020 data_out.ready SHALL be ignored (no backpressure); downstream always accepts.
REQ-021 decimation_ratio=0 SHALL be treated as 1; values above MAX_DECIMATION_RATIO SHALL saturate to MAX_DECIMATION_RATIO.
REQ-022 decimation_ratio is sampled per accepted sample; if a channel counter is already >= new N, the next sample for that channel SHALL complete the group.
REQ-023 With N=1, every accepted sample SHALL be reproduced one cycle later.
REQ-024 Back-to-back valid samples on the same or different channels SHALL be processed at one per clock with no stalls.

Reset
REQ-025 reset=0 SHALL asynchronously clear all counters and accumulators, data_out.valid, data_out.data and data_out.dest to 0, and data_in.ready to 0.
REQ-026 A partially accumulated group SHALL be discarded on reset; the first group after reset starts from a zero count.

Structure
REQ-027 A shared package SHALL hold the accumulator-width and counter-width localparam functions and the channel-index width constant.
REQ-028 A sub-module decimator_channel (one accumulator, one counter, and completion detect) SHALL be instantiated MAX_CHANNELS times via generate.
REQ-029 The top level SHALL hold the dest decode, the output mux/shift, and the output register.

Verification
REQ-030 Scenario: N=4, AVERAGING=1, dest=3, samples -10, -7, -3, 4 back-to-back -> one data_out pulse, data -4 (0xFFFC), dest 3, one cycle after the 4th sample.
REQ-031 Scenario: N=4, four samples 0x7FFF -> output 0x7FFF, with no overflow/wrap.
REQ-032 Scenario: N=4, four samples 0x8000 -> output 0x8000 (-32768).
REQ-033 Scenario: interleaved dest 0 and dest 1, N=2, samples 10, 100, 20, 200 -> outputs 15 (dest 0) then 150 (dest 1); dest 7 samples produce no output.
REQ-034 Scenario: AVERAGING=0, N=4, samples 1, 2, 3, 9 -> output 9; N=1 -> every sample echoed with a 1-cycle delay.
REQ-035 Scenario: reset asserted after 2 of 4 samples, then released and 4 samples of value 8 sent -> single output 8; all outputs are 0 during reset.
